// File: rtl/ucca_reset_ctrl_pkg.sv
// Shared definitions for the UCCA violation reset controller.
package ucca_reset_ctrl_pkg;
  typedef enum logic [1:0] {
    UCCA_RC_IDLE  = 2'd0,
    UCCA_RC_HOLD  = 2'd1,
    UCCA_RC_GUARD = 2'd2
  } ucca_rc_state_e;

  localparam logic [15:0] UCCA_RC_CLR_ADDR = 16'h0170;
endpackage

// File: rtl/ucca_viol_log.sv
// Sticky first-violation record with a saturating violation counter and
// software clear; an accepted violation takes priority over a same-cycle clear.
module ucca_viol_log #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             system_reset,
  input  logic             accept_i,
  input  logic [1:0]       cause_i,
  input  logic [15:0]      pc_i,
  input  logic             clr_i,
  output logic             viol_valid,
  output logic [1:0]       viol_cause,
  output logic [15:0]      viol_pc,
  output logic             viol_ovf,
  output logic [CNT_W-1:0] viol_count
);
  logic             valid_q, valid_d;
  logic [1:0]       cause_q, cause_d;
  logic [15:0]      pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge system_reset) begin
    if (system_reset) begin
      valid_q <= 1'b0;
      cause_q <= '0;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    valid_d = valid_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (accept_i) begin
      // A clear in the same cycle wipes the old record, so this becomes the first one.
      if (clr_i)             cnt_d = CNT_W'(1);
      else if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      if (!valid_q || clr_i) begin
        valid_d = 1'b1;
        cause_d = cause_i;
        pc_d    = pc_i;
        ovf_d   = 1'b0;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (clr_i) begin
      valid_d = 1'b0;
      cause_d = '0;
      pc_d    = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  assign viol_valid = valid_q;
  assign viol_cause = cause_q;
  assign viol_pc    = pc_q;
  assign viol_ovf   = ovf_q;
  assign viol_count = cnt_q;
endmodule

// File: rtl/ucca_reset_ctrl.sv
// Turns UCCA region-monitor violation flags into a fixed-length registered CPU
// reset pulse, with a guard state so lingering flags do not re-trigger.
module ucca_reset_ctrl
  import ucca_reset_ctrl_pkg::*;
#(
  parameter int          HOLD_CYCLES = 4,
  parameter int          CNT_W       = 8,
  parameter logic [15:0] CLR_ADDR    = UCCA_RC_CLR_ADDR
) (
  input  logic             clk,
  input  logic             system_reset,
  input  logic             return_reset,
  input  logic             stack_reset,
  input  logic [15:0]      pc,
  input  logic             data_en,
  input  logic             data_wr,
  input  logic [15:0]      data_addr,
  output logic             ucca_puc,
  output logic             viol_valid,
  output logic [1:0]       viol_cause,
  output logic [15:0]      viol_pc,
  output logic             viol_ovf,
  output logic [CNT_W-1:0] viol_count
);
  localparam int            HCW       = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

  ucca_rc_state_e state_q, state_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           puc_q, puc_d;
  logic           trig, clr, accept;

  assign trig = return_reset | stack_reset;
  assign clr  = data_en & data_wr & (data_addr == CLR_ADDR);

  always_ff @(posedge clk or posedge system_reset) begin
    if (system_reset) begin
      state_q    <= UCCA_RC_IDLE;
      hold_cnt_q <= '0;
      puc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      puc_q      <= puc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      UCCA_RC_IDLE: if (trig) begin
        state_d    = UCCA_RC_HOLD;
        hold_cnt_d = HOLD_LOAD;
      end
      UCCA_RC_HOLD: begin
        if (hold_cnt_q == '0) state_d = UCCA_RC_GUARD;
        else                  hold_cnt_d = hold_cnt_q - HCW'(1);
      end
      UCCA_RC_GUARD: if (!trig) state_d = UCCA_RC_IDLE;
      default: state_d = UCCA_RC_IDLE;
    endcase
  end

  // Pulse flop follows the next state so ucca_puc is high exactly while in HOLD.
  always_comb begin
    puc_d  = (state_d == UCCA_RC_HOLD);
    accept = (state_q == UCCA_RC_IDLE) & trig;
  end

  assign ucca_puc = puc_q;

  ucca_viol_log #(.CNT_W(CNT_W)) u_log (
    .clk         (clk),
    .system_reset(system_reset),
    .accept_i    (accept),
    .cause_i     ({stack_reset, return_reset}),
    .pc_i        (pc),
    .clr_i       (clr),
    .viol_valid  (viol_valid),
    .viol_cause  (viol_cause),
    .viol_pc     (viol_pc),
    .viol_ovf    (viol_ovf),
    .viol_count  (viol_count)
  );
endmodule
